// File: rtl/icw_ocw_control_if.sv
`default_nettype none
// ============================================================================
// Module      : icw_ocw_control_if
// Description : Bundle between the read/write logic (master side drives the
//               write strobes and command byte) and the ICW/OCW command
//               register block (slave side drives configuration, mask and
//               command pulses).
// Revision    : 1.0 - initial release
// ============================================================================
interface icw_ocw_control_if;
    // Write strobes and latched command byte
    logic       writeICW1;
    logic       writeICW2to4;
    logic       writeOCW1;
    logic       writeOCW2;
    logic       writeOCW3;
    logic [7:0] internalDataBus;

    // Configuration captured during initialisation
    logic       init_done;
    logic       ltim;
    logic       single_mode;
    logic       ic4;
    logic [4:0] vector_base;
    logic [7:0] cascade_cfg;
    logic       aeoi;
    logic       sfnm;
    logic       upm;

    // Operational state and command pulses
    logic [7:0] imr;
    logic       eoi_pulse;
    logic       eoi_specific;
    logic       rotate_pulse;
    logic       set_priority_pulse;
    logic       poll_pulse;
    logic [2:0] cmd_level;
    logic       rotate_aeoi;
    logic       special_mask;
    logic       read_isr;

    modport master (
        output writeICW1, writeICW2to4, writeOCW1, writeOCW2, writeOCW3,
               internalDataBus,
        input  init_done, ltim, single_mode, ic4, vector_base, cascade_cfg,
               aeoi, sfnm, upm, imr, eoi_pulse, eoi_specific, rotate_pulse,
               set_priority_pulse, poll_pulse, cmd_level, rotate_aeoi,
               special_mask, read_isr
    );

    modport slave (
        input  writeICW1, writeICW2to4, writeOCW1, writeOCW2, writeOCW3,
               internalDataBus,
        output init_done, ltim, single_mode, ic4, vector_base, cascade_cfg,
               aeoi, sfnm, upm, imr, eoi_pulse, eoi_specific, rotate_pulse,
               set_priority_pulse, poll_pulse, cmd_level, rotate_aeoi,
               special_mask, read_isr
    );
endinterface
`default_nettype wire

// File: rtl/icw_ocw_control.sv
`default_nettype none
// ============================================================================
// Module      : icw_ocw_control
// Description : 8259 initialisation/operation command register block.
//               Sequences ICW1..ICW4, holds configuration, interrupt mask and
//               OCW3 mode bits, and turns OCW2/OCW3 commands into one-cycle
//               pulses. All outputs are registered.
// Ports       : clk  - system clock (rising edge)
//               rst  - asynchronous active-high reset
//               bus  - slave side of icw_ocw_control_if (strobes + data in,
//                      configuration / mask / pulses out)
// Parameters  : IMR_RESET - mask value loaded by reset and by every ICW1
// Revision    : 1.0 - initial release
// ============================================================================
module icw_ocw_control #(
    parameter logic [7:0] IMR_RESET = 8'h00
) (
    input  wire logic           clk,
    input  wire logic           rst,
    icw_ocw_control_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_ICW2 = 3'd1,
        S_WAIT_ICW3 = 3'd2,
        S_WAIT_ICW4 = 3'd3,
        S_READY     = 3'd4
    } state_t;

    state_t     state_q;
    logic       init_done_q, ltim_q, single_mode_q, ic4_q;
    logic [4:0] vector_base_q;
    logic [7:0] cascade_cfg_q;
    logic       aeoi_q, sfnm_q, upm_q;
    logic [7:0] imr_q;
    logic       eoi_pulse_q, eoi_specific_q, rotate_pulse_q;
    logic       set_priority_pulse_q, poll_pulse_q;
    logic [2:0] cmd_level_q;
    logic       rotate_aeoi_q, special_mask_q, read_isr_q;

    logic [7:0] w_data;
    assign w_data = bus.internalDataBus;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q              <= S_IDLE;
            init_done_q          <= 1'b0;
            ltim_q               <= 1'b0;
            single_mode_q        <= 1'b0;
            ic4_q                <= 1'b0;
            vector_base_q        <= 5'd0;
            cascade_cfg_q        <= 8'd0;
            aeoi_q               <= 1'b0;
            sfnm_q               <= 1'b0;
            upm_q                <= 1'b0;
            imr_q                <= IMR_RESET;
            eoi_pulse_q          <= 1'b0;
            eoi_specific_q       <= 1'b0;
            rotate_pulse_q       <= 1'b0;
            set_priority_pulse_q <= 1'b0;
            poll_pulse_q         <= 1'b0;
            cmd_level_q          <= 3'd0;
            rotate_aeoi_q        <= 1'b0;
            special_mask_q       <= 1'b0;
            read_isr_q           <= 1'b0;
        end else begin
            // Pulses last one cycle unless re-armed by a strobe this cycle.
            eoi_pulse_q          <= 1'b0;
            rotate_pulse_q       <= 1'b0;
            set_priority_pulse_q <= 1'b0;
            poll_pulse_q         <= 1'b0;

            if (bus.writeICW1) begin
                // ICW1 restarts initialisation from any state and wins over
                // every other strobe in the same cycle.
                ltim_q         <= w_data[3];
                single_mode_q  <= w_data[1];
                ic4_q          <= w_data[0];
                imr_q          <= IMR_RESET;
                aeoi_q         <= 1'b0;
                sfnm_q         <= 1'b0;
                upm_q          <= 1'b0;
                rotate_aeoi_q  <= 1'b0;
                special_mask_q <= 1'b0;
                read_isr_q     <= 1'b0;
                init_done_q    <= 1'b0;
                state_q        <= S_WAIT_ICW2;
            end else begin
                case (state_q)
                    S_WAIT_ICW2: begin
                        if (bus.writeICW2to4) begin
                            vector_base_q <= w_data[7:3];
                            if (!single_mode_q) begin
                                state_q <= S_WAIT_ICW3;
                            end else if (ic4_q) begin
                                state_q <= S_WAIT_ICW4;
                            end else begin
                                state_q     <= S_READY;
                                init_done_q <= 1'b1;
                            end
                        end
                    end
                    S_WAIT_ICW3: begin
                        if (bus.writeICW2to4) begin
                            cascade_cfg_q <= w_data;
                            if (ic4_q) begin
                                state_q <= S_WAIT_ICW4;
                            end else begin
                                state_q     <= S_READY;
                                init_done_q <= 1'b1;
                            end
                        end
                    end
                    S_WAIT_ICW4: begin
                        if (bus.writeICW2to4) begin
                            aeoi_q      <= w_data[1];
                            upm_q       <= w_data[0];
                            sfnm_q      <= w_data[4];
                            state_q     <= S_READY;
                            init_done_q <= 1'b1;
                        end
                    end
                    S_READY: begin
                        if (bus.writeOCW1) begin
                            imr_q <= w_data;
                        end
                        if (bus.writeOCW2) begin
                            if (w_data[6]) begin
                                cmd_level_q <= w_data[2:0];
                            end
                            // Decode on {R, SL, EOI}
                            case (w_data[7:5])
                                3'b001, 3'b011: begin
                                    eoi_pulse_q    <= 1'b1;
                                    eoi_specific_q <= w_data[6];
                                end
                                3'b101, 3'b111: begin
                                    eoi_pulse_q    <= 1'b1;
                                    rotate_pulse_q <= 1'b1;
                                    eoi_specific_q <= w_data[6];
                                end
                                3'b110:  set_priority_pulse_q <= 1'b1;
                                3'b100:  rotate_aeoi_q        <= 1'b1;
                                3'b000:  rotate_aeoi_q        <= 1'b0;
                                default: ;
                            endcase
                        end
                        if (bus.writeOCW3) begin
                            if (w_data[6]) special_mask_q <= w_data[5];
                            if (w_data[2]) poll_pulse_q   <= 1'b1;
                            if (w_data[1]) read_isr_q     <= w_data[0];
                        end
                    end
                    default: ;  // IDLE: only ICW1 is accepted
                endcase
            end
        end
    end

    assign bus.init_done          = init_done_q;
    assign bus.ltim               = ltim_q;
    assign bus.single_mode        = single_mode_q;
    assign bus.ic4                = ic4_q;
    assign bus.vector_base        = vector_base_q;
    assign bus.cascade_cfg        = cascade_cfg_q;
    assign bus.aeoi               = aeoi_q;
    assign bus.sfnm               = sfnm_q;
    assign bus.upm                = upm_q;
    assign bus.imr                = imr_q;
    assign bus.eoi_pulse          = eoi_pulse_q;
    assign bus.eoi_specific       = eoi_specific_q;
    assign bus.rotate_pulse       = rotate_pulse_q;
    assign bus.set_priority_pulse = set_priority_pulse_q;
    assign bus.poll_pulse         = poll_pulse_q;
    assign bus.cmd_level          = cmd_level_q;
    assign bus.rotate_aeoi        = rotate_aeoi_q;
    assign bus.special_mask       = special_mask_q;
    assign bus.read_isr           = read_isr_q;

endmodule
`default_nettype wire

// File: tb/tb_icw_ocw_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_icw_ocw_control
// Description : Self-checking bench for icw_ocw_control. Each driven strobe
//               pushes the expected post-edge output snapshot to a queue; the
//               snapshot is popped and compared once the edge has taken it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icw_ocw_control;

    typedef struct packed {
        logic       init_done;
        logic       ltim;
        logic       single_mode;
        logic       ic4;
        logic [4:0] vector_base;
        logic [7:0] cascade_cfg;
        logic       aeoi;
        logic       sfnm;
        logic       upm;
        logic [7:0] imr;
        logic       eoi_pulse;
        logic       eoi_specific;
        logic       rotate_pulse;
        logic       set_priority_pulse;
        logic       poll_pulse;
        logic [2:0] cmd_level;
        logic       rotate_aeoi;
        logic       special_mask;
        logic       read_isr;
    } snap_t;

    // Strobe encodings {ICW1, ICW2to4, OCW1, OCW2, OCW3}
    localparam logic [4:0] c_ICW1  = 5'b10000;
    localparam logic [4:0] c_A0    = 5'b01100;
    localparam logic [4:0] c_OCW1  = 5'b00100;
    localparam logic [4:0] c_OCW2  = 5'b00010;
    localparam logic [4:0] c_OCW3  = 5'b00001;

    logic clk;
    logic rst;

    icw_ocw_control_if bus ();

    icw_ocw_control #(.IMR_RESET(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    snap_t exp;
    snap_t exp_q[$];
    int    n_cmp;
    int    n_err;

    function automatic snap_t sample();
        snap_t s;
        s.init_done          = bus.init_done;
        s.ltim               = bus.ltim;
        s.single_mode        = bus.single_mode;
        s.ic4                = bus.ic4;
        s.vector_base        = bus.vector_base;
        s.cascade_cfg        = bus.cascade_cfg;
        s.aeoi               = bus.aeoi;
        s.sfnm               = bus.sfnm;
        s.upm                = bus.upm;
        s.imr                = bus.imr;
        s.eoi_pulse          = bus.eoi_pulse;
        s.eoi_specific       = bus.eoi_specific;
        s.rotate_pulse       = bus.rotate_pulse;
        s.set_priority_pulse = bus.set_priority_pulse;
        s.poll_pulse         = bus.poll_pulse;
        s.cmd_level          = bus.cmd_level;
        s.rotate_aeoi        = bus.rotate_aeoi;
        s.special_mask       = bus.special_mask;
        s.read_isr           = bus.read_isr;
        return s;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, want);
        end
    endtask

    task automatic compare(input string tag);
        snap_t want;
        if (exp_q.size() == 0) begin
            check_eq({tag, " (scoreboard empty)"}, 64'd1, 64'd0);
        end else begin
            want = exp_q.pop_front();
            check_eq(tag, 64'(sample()), 64'(want));
        end
    endtask

    task automatic clear_pulses();
        exp.eoi_pulse          = 1'b0;
        exp.rotate_pulse       = 1'b0;
        exp.set_priority_pulse = 1'b0;
        exp.poll_pulse         = 1'b0;
    endtask

    // Entered at a falling edge; exp already holds the post-edge expectation.
    task automatic step(input logic [4:0] stb, input logic [7:0] d, input string tag);
        {bus.writeICW1, bus.writeICW2to4, bus.writeOCW1, bus.writeOCW2, bus.writeOCW3} = stb;
        bus.internalDataBus = d;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        {bus.writeICW1, bus.writeICW2to4, bus.writeOCW1, bus.writeOCW2, bus.writeOCW3} = 5'b0;
        bus.internalDataBus = 8'h00;
        compare(tag);
        clear_pulses();
        @(negedge clk);
    endtask

    task automatic reset_exp();
        exp = '0;
        exp.imr = 8'h00;
    endtask

    // ICW1 side effects on the expectation (config bits from the byte).
    task automatic icw1_exp(input logic [7:0] d);
        exp.ltim = d[3]; exp.single_mode = d[1]; exp.ic4 = d[0];
        exp.imr = 8'h00; exp.aeoi = 0; exp.sfnm = 0; exp.upm = 0;
        exp.rotate_aeoi = 0; exp.special_mask = 0; exp.read_isr = 0;
        exp.init_done = 0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clk = 1'b0;
        rst = 1'b1;
        {bus.writeICW1, bus.writeICW2to4, bus.writeOCW1, bus.writeOCW2, bus.writeOCW3} = 5'b0;
        bus.internalDataBus = 8'h00;
        reset_exp();

        #1;
        exp_q.push_back(exp);
        compare("reset_state");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Full init
        icw1_exp(8'h11);                       step(c_ICW1, 8'h11, "full_icw1");
        exp.vector_base = 5'h04;               step(c_A0,   8'h20, "full_icw2");
        exp.cascade_cfg = 8'h04;               step(c_A0,   8'h04, "full_icw3");
        exp.aeoi = 1; exp.upm = 1; exp.init_done = 1;
                                               step(c_A0,   8'h03, "full_icw4");
        exp.imr = 8'hF0;                       step(c_A0,   8'hF0, "ocw1_mask");

        // OCW2 sweep (back-to-back strobes)
        exp.eoi_pulse = 1; exp.eoi_specific = 0;
                                               step(c_OCW2, 8'h20, "ocw2_nseoi");
        exp.eoi_pulse = 1; exp.eoi_specific = 1; exp.cmd_level = 3'd3;
                                               step(c_OCW2, 8'h63, "ocw2_seoi");
        exp.eoi_pulse = 1; exp.rotate_pulse = 1; exp.eoi_specific = 1; exp.cmd_level = 3'd5;
                                               step(c_OCW2, 8'hE5, "ocw2_rot_seoi");
        exp.set_priority_pulse = 1; exp.cmd_level = 3'd7;
                                               step(c_OCW2, 8'hC7, "ocw2_setpri");
        exp.eoi_pulse = 1; exp.eoi_specific = 0;
                                               step(c_OCW2, 8'h20, "ocw2_nseoi2");
        exp.rotate_aeoi = 1;                   step(c_OCW2, 8'h80, "ocw2_rot_aeoi_set");
        exp.rotate_aeoi = 0;                   step(c_OCW2, 8'h00, "ocw2_rot_aeoi_clr");

        // OCW3
        exp.special_mask = 1;                  step(c_OCW3, 8'h68, "ocw3_smm_set");
        exp.read_isr = 1;                      step(c_OCW3, 8'h0B, "ocw3_rr_isr");
        exp.poll_pulse = 1;                    step(c_OCW3, 8'h0C, "ocw3_poll1");
        exp.poll_pulse = 1;                    step(c_OCW3, 8'h0C, "ocw3_poll2");
                                               step(5'b0,   8'h00, "poll_drop");
        exp.special_mask = 0;                  step(c_OCW3, 8'h48, "ocw3_smm_clr");

        // ICW1 wins over a simultaneous OCW2 EOI
        icw1_exp(8'h33);                       step(c_ICW1 | c_OCW2, 8'h33, "icw1_beats_ocw2");

        // Short init, with OCW strobes ignored in WAIT_ICW2
        icw1_exp(8'h12);                       step(c_ICW1, 8'h12, "short_icw1");
                                               step(c_OCW2, 8'h20, "wait_ocw2_ignored");
                                               step(c_OCW3, 8'h0C, "wait_ocw3_ignored");
                                               step(c_OCW1, 8'h55, "wait_ocw1_ignored");
        exp.vector_base = 5'h08; exp.init_done = 1;
                                               step(c_A0,   8'h40, "short_icw2");
        exp.imr = 8'hF0;                       step(c_A0,   8'hF0, "short_ocw1");

        // Restart from WAIT_ICW3
        icw1_exp(8'h11);                       step(c_ICW1, 8'h11, "restart_icw1a");
        exp.vector_base = 5'h04;               step(c_A0,   8'h20, "restart_icw2a");
                                               step(c_ICW1, 8'h11, "restart_in_w3");
        exp.vector_base = 5'h09;               step(c_A0,   8'h48, "restart_icw2b");
        exp.cascade_cfg = 8'hA5;               step(c_A0,   8'hA5, "restart_icw3");

        // Asynchronous reset mid-init, checked before any clock edge
        #2;
        rst = 1'b1;
        reset_exp();
        #1;
        exp_q.push_back(exp);
        compare("async_reset");
        @(negedge clk);
        rst = 1'b0;

        // First strobe accepted on the first edge after release
        icw1_exp(8'h1B);                       step(c_ICW1, 8'h1B, "post_rst_icw1");
        exp.vector_base = 5'h1F;               step(c_A0,   8'hF8, "post_rst_icw2");
        exp.aeoi = 1; exp.sfnm = 1; exp.init_done = 1;
                                               step(c_A0,   8'h12, "post_rst_icw4");
        exp.eoi_pulse = 1; exp.rotate_pulse = 1; exp.eoi_specific = 0;
                                               step(c_OCW2, 8'hA0, "post_rst_rot_eoi");

        if (exp_q.size() != 0) check_eq("scoreboard_drain", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icw_ocw_control.md
# icw_ocw_control

Initialization and operation command register block of the 8259 PIC, directly downstream of the read/write logic. It consumes the one-cycle write strobes (ICW1, ICW2–4, OCW1, OCW2, OCW3) and the latched internal data bus. It sequences ICW1→ICW2→ICW3→ICW4 with an init state machine and holds the resulting configuration, the interrupt mask and the OCW3 mode bits. It also turns OCW2/OCW3 commands into one-cycle pulses for the priority resolver and in-service logic.

## Interface
- IMR_RESET, 8'h00, IMR value loaded by reset and by every ICW1
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- writeICW1, writeICW2to4, writeOCW1, writeOCW2, writeOCW3  in  1 each  one-cycle write strobes from the read/write logic
- internalDataBus  in  8  command byte, valid while any strobe is high
- init_done  out  1  high in READY
- ltim, single_mode, ic4  out  1 each  ICW1 bits 3, 1, 0
- vector_base  out  5  ICW2 bits 7:3
- cascade_cfg  out  8  ICW3 byte
- aeoi, sfnm, upm  out  1 each  ICW4 bits 1, 4, 0
- imr  out  8  interrupt mask (OCW1)
- eoi_pulse, eoi_specific  out  1 each  EOI command and its specific/non-specific flag
- rotate_pulse, set_priority_pulse, poll_pulse  out  1 each  one-cycle command pulses
- cmd_level  out  3  OCW2 L2:L0 of the last specific command
- rotate_aeoi, special_mask, read_isr  out  1 each  persistent mode bits

## Operation
- States: IDLE (after reset), WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
- ICW1 in any state:
  - capture ltim, single_mode and ic4
  - imr←IMR_RESET; clear aeoi/sfnm/upm, rotate_aeoi, special_mask, read_isr
  - go to WAIT_ICW2
  - ICW1 beats any simultaneous strobe.
- writeICW2to4 and writeOCW1 arrive together (both mean A0=1). The state decides which applies: the ICW path in the WAIT_* states, OCW1 in READY.
- WAIT_ICW2: vector_base←data[7:3]. Next state is WAIT_ICW3 if !single_mode, else WAIT_ICW4 if ic4, else READY.
- WAIT_ICW3: cascade_cfg←data. Next state is WAIT_ICW4 if ic4, else READY.
- WAIT_ICW4: aeoi←d[1], upm←d[0], sfnm←d[4]. Next state is READY.
- READY, OCW1: imr←data.
- READY, OCW2, decoded on R,SL,EOI = d[7:5], with cmd_level←d[2:0] whenever SL=1:
  - 001: eoi_pulse, eoi_specific=0
  - 011: eoi_pulse, eoi_specific=1
  - 101: eoi_pulse + rotate_pulse, eoi_specific=0
  - 111: eoi_pulse + rotate_pulse, eoi_specific=1
  - 110: set_priority_pulse
  - 100: rotate_aeoi←1
  - 000: rotate_aeoi←0
  - 010: no operation
- READY, OCW3:
  - if d[6] (ESMM), special_mask←d[5]
  - if d[2], poll_pulse
  - if d[1] (RR), read_isr←d[0]
- OCW1/2/3 strobes outside READY are ignored and produce no pulses.
- ICW2to4 strobes in IDLE or READY are ignored (in READY they act as OCW1).

## Timing
- Every output is registered. A strobe high in cycle N updates outputs on the rising edge that ends N, so they are visible in cycle N+1.
- Pulses are high for exactly one cycle per strobe. Back-to-back strobes give back-to-back pulses.
- eoi_specific and cmd_level are valid in the same cycle as their pulse and hold until the next OCW2.
- Reset (asynchronous, any cycle, including mid-init) forces:
  - state IDLE
  - imr=IMR_RESET
  - every other output 0 (init_done=0, all pulses 0)
- Reset release: the first strobe can be taken on the first rising edge while rst is low.
- ICW1 during WAIT_ICW3 or WAIT_ICW4 abandons that sequence and restarts at WAIT_ICW2. Previously captured vector_base and cascade_cfg are kept until they are overwritten.

## Test plan
- Full init: ICW1=0x11, ICW2=0x20, ICW3=0x04, ICW4=0x03 → vector_base=0x04, cascade_cfg=0x04, aeoi=1, upm=1, init_done=1 in the cycle after ICW4.
- Short init: ICW1=0x12, ICW2=0x40 → READY straight after ICW2, vector_base=0x08, ICW3/ICW4 skipped. A following A0=1 write of 0xF0 gives imr=0xF0.
- OCW2 sweep in READY: 0x20 → eoi_pulse only, specific=0. 0x63 → eoi_pulse, specific=1, cmd_level=3. 0xE5 → eoi_pulse + rotate_pulse, cmd_level=5. 0xC7 → set_priority_pulse, cmd_level=7. 0x80 → rotate_aeoi=1. 0x00 → rotate_aeoi=0.
- OCW3: 0x68 → special_mask=1. 0x0B → read_isr=1. 0x0C → poll_pulse for one cycle, read_isr unchanged. 0x48 → special_mask=0.
- OCW strobes while in WAIT_ICW2 → no pulses, imr unchanged.
- Restart and reset: ICW1 issued in WAIT_ICW3 → WAIT_ICW2 with imr=0x00. rst asserted mid-init → all outputs at reset values immediately, without waiting for a clock edge.
